slap_video_mixer: RTL and testbench

- Downstream consumer of the sprite layer's 8-bit pixel output. Merges the sprite, foreground (text) and background tile pixels by fixed priority.
- Translates the winning pixel through three downloadable 4-bit colour PROMs (R, G, B). The result is registered RGB444 for the video output, with blanking and a line-start sprite mask.
- Runs on master_clk; pixel rate is set by a clock-enable.

---
 rtl/slap_video_mixer_pkg.sv | 31 +++
 rtl/slap_video_mixer_palette_prom_4x256.sv | 33 +++
 rtl/slap_video_mixer.sv | 170 +++++++++++++++++
 tb/tb_slap_video_mixer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/slap_video_mixer_pkg.sv
// Shared widths, layer-select encodings and palette-index helper for slap_video_mixer.
package slap_video_mixer_pkg;

  localparam int PIX_W = 8;
  localparam int IDX_W = 8;
  localparam int COL_W = 4;
  localparam int CNT_W = 4;

  localparam logic [1:0] FG_BANK = 2'b11;

  localparam logic [1:0] SEL_BG   = 2'd0;
  localparam logic [1:0] SEL_SPR  = 2'd1;
  localparam logic [1:0] SEL_FG   = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  localparam logic [IDX_W-1:0] DN_ADDR_MASK = 8'hFF;

  // Palette index of the winning layer; no layer selected maps to address 0.
  function automatic logic [IDX_W-1:0] pal_index(input logic [1:0] sel,
                                                 input logic [PIX_W-1:0] fg,
                                                 input logic [PIX_W-1:0] spr,
                                                 input logic [PIX_W-1:0] bg);
    case (sel)
      SEL_FG:  pal_index = {FG_BANK, fg[7:2]};
      SEL_SPR: pal_index = spr;
      SEL_BG:  pal_index = bg;
      default: pal_index = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/slap_video_mixer_palette_prom_4x256.sv
// 256x4 downloadable colour PROM with a registered read port.
module palette_prom_4x256
  import slap_video_mixer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [COL_W-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [COL_W-1:0] rdata
);

  logic [COL_W-1:0] mem_r [256];

  // Download write port; the storage itself is not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read; a colliding write is seen only by the following read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 4'h0;
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/slap_video_mixer.sv
// Sprite/FG/BG priority mixer with RGB444 palette lookup and line-start sprite mask.
// Optional per-layer enables when MIXER_LAYER_MASK_EN is defined.
module slap_video_mixer
  import slap_video_mixer_pkg::*;
#(
  parameter int SPR_MASK_PIX = 8,
  parameter int PIPE_LAT     = 3
) (
  input  logic        master_clk,
  input  logic        nRESET,
  input  logic        pixel_ce,
  input  logic [7:0]  SPR_PIX,
  input  logic [7:0]  FG_PIX,
  input  logic [7:0]  BG_PIX,
  input  logic        HBLANK,
  input  logic        VBLANK,
  input  logic [24:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        dn_wr,
  input  logic        palr_cs_i,
  input  logic        palg_cs_i,
  input  logic        palb_cs_i,
`ifdef MIXER_LAYER_MASK_EN
  input  logic [2:0]  LAYER_EN,
`endif
  input  logic        DL_ACTIVE,
  output logic [3:0]  RED,
  output logic [3:0]  GREEN,
  output logic [3:0]  BLUE,
  output logic        BLANK_OUT
);

  localparam logic [CNT_W-1:0] MASK_LOAD = CNT_W'(SPR_MASK_PIX);

  if (PIPE_LAT != 3) begin : g_bad_pipe_lat
    $error("slap_video_mixer: PIPE_LAT is fixed at 3");
  end

  logic [1:0]       rst_sync_r;
  logic             rst_n_s;
  logic [2:0]       layer_in_s;
  logic [PIX_W-1:0] s1_spr_r, s1_fg_r, s1_bg_r;
  logic             s1_blank_r, s1_hblank_r;
  logic [2:0]       s1_layer_r;
  logic [CNT_W-1:0] mask_cnt_r;
  logic             hb_fall_s;
  logic [1:0]       sel_s;
  logic [IDX_W-1:0] idx_s;
  logic             s2_blank_r;
  logic [2:0]       cs_s;
  logic             one_cs_s, wr_ok_s;
  logic [IDX_W-1:0] dn_waddr_s;
  logic [COL_W-1:0] red_q_s, green_q_s, blue_q_s;
  logic             unused_dn_s;

`ifdef MIXER_LAYER_MASK_EN
  assign layer_in_s = LAYER_EN;
`else
  assign layer_in_s = 3'b111;
`endif

  // Reset synchronizer: asserts immediately, releases on master_clk.
  always_ff @(posedge master_clk or negedge nRESET) begin
    if (!nRESET) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end
  assign rst_n_s = rst_sync_r[1];

  // Stage 1: capture layer pixels and blanking.
  always_ff @(posedge master_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      s1_spr_r    <= 8'h00;
      s1_fg_r     <= 8'h00;
      s1_bg_r     <= 8'h00;
      s1_blank_r  <= 1'b1;
      s1_hblank_r <= 1'b1;
      s1_layer_r  <= 3'b000;
    end else if (pixel_ce) begin
      s1_spr_r    <= SPR_PIX;
      s1_fg_r     <= FG_PIX;
      s1_bg_r     <= BG_PIX;
      s1_blank_r  <= HBLANK | VBLANK;
      s1_hblank_r <= HBLANK;
      s1_layer_r  <= layer_in_s;
    end
  end

  assign hb_fall_s = s1_hblank_r & ~HBLANK;

  // Line-start sprite mask: reload on HBLANK fall (wins over decrement), saturate at 0.
  always_ff @(posedge master_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      mask_cnt_r <= MASK_LOAD;
    end else if (pixel_ce) begin
      if (hb_fall_s) begin
        mask_cnt_r <= MASK_LOAD;
      end else if (mask_cnt_r != 4'd0) begin
        mask_cnt_r <= mask_cnt_r - 4'd1;
      end
    end
  end

  // Fixed priority FG > unmasked SPR > BG.
  always_comb begin
    sel_s = SEL_NONE;
    if (s1_layer_r[0] && (s1_fg_r[1:0] != 2'b00)) begin
      sel_s = SEL_FG;
    end else if (s1_layer_r[1] && (s1_spr_r[3:0] != 4'h0) && (mask_cnt_r == 4'd0)) begin
      sel_s = SEL_SPR;
    end else if (s1_layer_r[2]) begin
      sel_s = SEL_BG;
    end else begin
      sel_s = SEL_NONE;
    end
    idx_s = pal_index(sel_s, s1_fg_r, s1_spr_r, s1_bg_r);
  end

  // Stage 2: blank carried alongside the PROM read of idx_s.
  always_ff @(posedge master_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      s2_blank_r <= 1'b1;
    end else if (pixel_ce) begin
      s2_blank_r <= s1_blank_r;
    end
  end

  assign cs_s        = {palr_cs_i, palg_cs_i, palb_cs_i};
  assign one_cs_s    = (cs_s == 3'b100) || (cs_s == 3'b010) || (cs_s == 3'b001);
  assign wr_ok_s     = dn_wr & one_cs_s;
  assign dn_waddr_s  = dn_addr[7:0] & DN_ADDR_MASK;
  assign unused_dn_s = ^{dn_addr[24:8], dn_data[7:4]};

  palette_prom_4x256 u_prom_r (
    .clk(master_clk), .rst_n(rst_n_s), .we(wr_ok_s & palr_cs_i), .waddr(dn_waddr_s),
    .wdata(dn_data[3:0]), .re(pixel_ce), .raddr(idx_s), .rdata(red_q_s)
  );
  palette_prom_4x256 u_prom_g (
    .clk(master_clk), .rst_n(rst_n_s), .we(wr_ok_s & palg_cs_i), .waddr(dn_waddr_s),
    .wdata(dn_data[3:0]), .re(pixel_ce), .raddr(idx_s), .rdata(green_q_s)
  );
  palette_prom_4x256 u_prom_b (
    .clk(master_clk), .rst_n(rst_n_s), .we(wr_ok_s & palb_cs_i), .waddr(dn_waddr_s),
    .wdata(dn_data[3:0]), .re(pixel_ce), .raddr(idx_s), .rdata(blue_q_s)
  );

  // Stage 3: blanked or download-suppressed colour output.
  always_ff @(posedge master_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      RED       <= 4'h0;
      GREEN     <= 4'h0;
      BLUE      <= 4'h0;
      BLANK_OUT <= 1'b1;
    end else if (pixel_ce) begin
      BLANK_OUT <= s2_blank_r;
      if (s2_blank_r || DL_ACTIVE) begin
        RED   <= 4'h0;
        GREEN <= 4'h0;
        BLUE  <= 4'h0;
      end else begin
        RED   <= red_q_s;
        GREEN <= green_q_s;
        BLUE  <= blue_q_s;
      end
    end
  end

endmodule

// File: tb/tb_slap_video_mixer.sv
// Self-checking bench for slap_video_mixer: two instances (mask 8 and mask 0) against a reference model.
module tb_slap_video_mixer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nRESET = 1'b1;
  logic        pixel_ce, HBLANK, VBLANK, dn_wr, palr, palg, palb, DL_ACTIVE;
  logic [7:0]  SPR_PIX, FG_PIX, BG_PIX, dn_data;
  logic [24:0] dn_addr;
  logic [3:0]  red8, green8, blue8, red0, green0, blue0;
  logic        blank8, blank0;

  slap_video_mixer #(.SPR_MASK_PIX(8)) dut8 (
    .master_clk(clk), .nRESET(nRESET), .pixel_ce(pixel_ce),
    .SPR_PIX(SPR_PIX), .FG_PIX(FG_PIX), .BG_PIX(BG_PIX), .HBLANK(HBLANK), .VBLANK(VBLANK),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
    .palr_cs_i(palr), .palg_cs_i(palg), .palb_cs_i(palb),
`ifdef MIXER_LAYER_MASK_EN
    .LAYER_EN(3'b111),
`endif
    .DL_ACTIVE(DL_ACTIVE), .RED(red8), .GREEN(green8), .BLUE(blue8), .BLANK_OUT(blank8)
  );

  slap_video_mixer #(.SPR_MASK_PIX(0)) dut0 (
    .master_clk(clk), .nRESET(nRESET), .pixel_ce(pixel_ce),
    .SPR_PIX(SPR_PIX), .FG_PIX(FG_PIX), .BG_PIX(BG_PIX), .HBLANK(HBLANK), .VBLANK(VBLANK),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
    .palr_cs_i(palr), .palg_cs_i(palg), .palb_cs_i(palb),
`ifdef MIXER_LAYER_MASK_EN
    .LAYER_EN(3'b111),
`endif
    .DL_ACTIVE(DL_ACTIVE), .RED(red0), .GREEN(green0), .BLUE(blue0), .BLANK_OUT(blank0)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: palette contents plus the colour expected for pixels in flight.
  logic [3:0]  m_r [256];
  logic [3:0]  m_g [256];
  logic [3:0]  m_b [256];
  logic [7:0]  s1_idx [2];
  logic [11:0] s2_rgb [2];
  logic [12:0] exp_out [2];
  logic        s1_blank, s2_blank, prev_hb;
  int          pos;

  function automatic logic [7:0] ref_index(input logic [7:0] fg, input logic [7:0] spr,
                                           input logic [7:0] bg, input logic masked);
    if (fg[1:0] != 2'b00) return {2'b11, fg[7:2]};
    else if ((spr[3:0] != 4'h0) && !masked) return spr;
    else return bg;
  endfunction

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [12:0] exp8, input logic [12:0] exp0);
    chk({tag, "_m8"}, {red8, green8, blue8, blank8}, exp8);
    chk({tag, "_m0"}, {red0, green0, blue0, blank0}, exp0);
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      s1_idx[l]  = 8'h00;
      s2_rgb[l]  = 12'h000;
      exp_out[l] = 13'h0001;
    end
    s1_blank = 1'b1;
    s2_blank = 1'b1;
    prev_hb  = 1'b1;
    pos      = 0;
  endtask

  // One master_clk edge: advance the model on pixel_ce, then compare both instances.
  task automatic tick();
    logic [7:0] a;
    @(posedge clk);
    #1;
    if (pixel_ce) begin
      for (int l = 0; l < 2; l++) begin
        exp_out[l] = {((s2_blank | DL_ACTIVE) ? 12'h000 : s2_rgb[l]), s2_blank};
        s2_rgb[l]  = {m_r[s1_idx[l]], m_g[s1_idx[l]], m_b[s1_idx[l]]};
      end
      s2_blank = s1_blank;
      pos      = (prev_hb && !HBLANK) ? 0 : ((pos < 64) ? pos + 1 : pos);
      prev_hb  = HBLANK;
      s1_idx[0] = ref_index(FG_PIX, SPR_PIX, BG_PIX, pos < 8);
      s1_idx[1] = ref_index(FG_PIX, SPR_PIX, BG_PIX, 1'b0);
      s1_blank  = HBLANK | VBLANK;
    end
    if (dn_wr && ($countones({palr, palg, palb}) == 1)) begin
      a = dn_addr[7:0];
      if (palr) m_r[a] = dn_data[3:0];
      if (palg) m_g[a] = dn_data[3:0];
      if (palb) m_b[a] = dn_data[3:0];
    end
    chk2("model", exp_out[0], exp_out[1]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pix(input logic [7:0] spr, input logic [7:0] fg, input logic [7:0] bg,
                     input logic hb, input logic vb);
    SPR_PIX = spr; FG_PIX = fg; BG_PIX = bg; HBLANK = hb; VBLANK = vb;
    pixel_ce = 1'b1;
    tick();
    pixel_ce = 1'b0;
  endtask

  task automatic dl(input logic [2:0] cs, input logic [7:0] a, input logic [3:0] d);
    {palr, palg, palb} = cs;
    dn_addr = {17'($urandom()), a};
    dn_data = {4'($urandom()), d};
    dn_wr = 1'b1;
    tick();
    dn_wr = 1'b0;
    {palr, palg, palb} = 3'b000;
  endtask

  task automatic rand_stream(input int n, input int gap, input bit stalls);
    logic [7:0] f, s;
    for (int i = 0; i < n; i++) begin
      f = 8'($urandom());
      if ($urandom_range(0, 1) == 0) f[1:0] = 2'b00;
      s = 8'($urandom());
      if ($urandom_range(0, 3) == 0) s[3:0] = 4'h0;
      pix(s, f, 8'($urandom()), (i % 24) >= 20, (i % 96) >= 90);
      if (gap > 1) idle(gap - 1);
      if (stalls && ($urandom_range(0, 15) == 0)) idle(20);
    end
  endtask

  initial begin
    pixel_ce = 1'b0; HBLANK = 1'b1; VBLANK = 1'b0; DL_ACTIVE = 1'b0;
    SPR_PIX = 8'h00; FG_PIX = 8'h00; BG_PIX = 8'h00;
    dn_wr = 1'b0; dn_addr = 25'h0; dn_data = 8'h00; {palr, palg, palb} = 3'b000;
    model_reset();
    #2 nRESET = 1'b0;
    idle(3);
    nRESET = 1'b1;
    idle(4);
    chk2("reset_state", 13'h0001, 13'h0001);

    // Fill all palettes; interleave multi-select writes that must be ignored.
    for (int a = 0; a < 256; a++) begin
      dl(3'b100, 8'(a), 4'($urandom()));
      dl(3'b010, 8'(a), 4'($urandom()));
      dl(3'b001, 8'(a), 4'($urandom()));
      if ((a % 32) == 0) dl(3'b110, 8'(a), 4'($urandom()));
    end

    rand_stream(150, 1, 1'b0);

    // Mid-frame asynchronous reset, then release with no pixel_ce.
    #3 nRESET = 1'b0;
    #1;
    chk2("async_reset", 13'h0001, 13'h0001);
    model_reset();
    idle(2);
    nRESET = 1'b1;
    idle(5);
    chk2("post_release_hold", 13'h0001, 13'h0001);

    // Latency: A/5/F appears exactly on the third pixel_ce.
    dl(3'b100, 8'h25, 4'hA); dl(3'b010, 8'h25, 4'h5); dl(3'b001, 8'h25, 4'hF);
    dl(3'b100, 8'h26, 4'h0); dl(3'b010, 8'h26, 4'h0); dl(3'b001, 8'h26, 4'h0);
    pix(8'h00, 8'h00, 8'h26, 1'b1, 1'b0);
    pix(8'h00, 8'h00, 8'h26, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) pix(8'h00, 8'h00, 8'h26, 1'b0, 1'b0);
    pix(8'h00, 8'h00, 8'h25, 1'b0, 1'b0);
    pix(8'h00, 8'h00, 8'h25, 1'b0, 1'b0);
    chk2("lat_2ce", 13'h0000, 13'h0000);
    pix(8'h00, 8'h00, 8'h25, 1'b0, 1'b0);
    chk2("lat_3ce", 13'h14BE, 13'h14BE);

    // Priority: FG bank C2, then sprite 37, then background 10.
    dl(3'b100, 8'hC2, 4'hC); dl(3'b010, 8'hC2, 4'hC); dl(3'b001, 8'hC2, 4'hC);
    dl(3'b100, 8'h37, 4'h3); dl(3'b010, 8'h37, 4'h3); dl(3'b001, 8'h37, 4'h3);
    dl(3'b100, 8'h10, 4'h1); dl(3'b010, 8'h10, 4'h1); dl(3'b001, 8'h10, 4'h1);
    pix(8'h37, 8'h09, 8'h10, 1'b0, 1'b0);
    pix(8'h37, 8'h08, 8'h10, 1'b0, 1'b0);
    pix(8'h30, 8'h08, 8'h10, 1'b0, 1'b0);
    chk2("prio_fg", 13'h1998, 13'h1998);
    pix(8'h30, 8'h08, 8'h10, 1'b0, 1'b0);
    chk2("prio_spr", 13'h0666, 13'h0666);
    pix(8'h30, 8'h08, 8'h10, 1'b0, 1'b0);
    chk2("prio_bg", 13'h0222, 13'h0222);

    // Line-start mask: eight pixels of BG, then the sprite; mask 0 shows the sprite at once.
    for (int i = 0; i < 3; i++) pix(8'h37, 8'h00, 8'h10, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      pix(8'h37, 8'h00, 8'h10, 1'b0, 1'b0);
      if (i >= 2) chk2("line_mask", ((i - 2) < 8) ? 13'h0222 : 13'h0666, 13'h0666);
    end

    // Sparse pixel_ce with long stalls.
    rand_stream(120, 4, 1'b1);

    // Download in progress blanks RGB but keeps the pipeline moving.
    DL_ACTIVE = 1'b1;
    for (int i = 0; i < 4; i++) pix(8'h00, 8'h00, 8'h10, 1'b0, 1'b0);
    chk2("dl_active", 13'h0000, 13'h0000);
    DL_ACTIVE = 1'b0;

    // Same-edge write and read of 0x40: old value first, new value next.
    dl(3'b100, 8'h40, 4'h5); dl(3'b010, 8'h40, 4'h5); dl(3'b001, 8'h40, 4'h5);
    for (int i = 0; i < 3; i++) pix(8'h00, 8'h00, 8'h40, 1'b0, 1'b0);
    {palr, palg, palb} = 3'b100; dn_addr = 25'h0000040; dn_data = 8'h0A; dn_wr = 1'b1;
    pix(8'h00, 8'h00, 8'h40, 1'b0, 1'b0);
    dn_wr = 1'b0; {palr, palg, palb} = 3'b000;
    pix(8'h00, 8'h00, 8'h40, 1'b0, 1'b0);
    chk2("collide_old", 13'h0AAA, 13'h0AAA);
    pix(8'h00, 8'h00, 8'h40, 1'b0, 1'b0);
    chk2("collide_new", 13'h14AA, 13'h14AA);

    rand_stream(60, 2, 1'b0);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
